// File: rtl/cart_loader.sv
`timescale 1ns/1ps
// cart_loader: streams the HPS ioctl cartridge image into RAM port B at a
// fixed base, optionally clearing the region first, with the CPU held in reset.
module cart_loader #(
    parameter int                      data_width_g = 8,
    parameter int                      addr_width_g = 14,
    parameter int                      BASE_ADDR    = 'h400,
    parameter int                      INDEX_MATCH  = 1,
    parameter bit                      CLEAR_EN     = 1'b1,
    parameter logic [data_width_g-1:0] FILL_VALUE   = '0
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      ioctl_download,
    input  logic [7:0]                ioctl_index,
    input  logic                      ioctl_wr,
    input  logic [26:0]               ioctl_addr,
    input  logic [data_width_g-1:0]   ioctl_dout,
    output logic                      ioctl_wait,
    output logic                      ram_cs_b,
    output logic                      ram_we_b,
    output logic [addr_width_g-1:0]   ram_ad_b,
    output logic [data_width_g-1:0]   ram_d_b,
    output logic                      cpu_hold,
    output logic                      load_done,
    output logic [addr_width_g:0]     load_bytes,
    output logic                      load_overflow
);

    localparam int                      LP_REGION_I = (1 << addr_width_g) - BASE_ADDR;
    localparam logic [27:0]             LP_REGION   = 28'(LP_REGION_I);
    localparam logic [addr_width_g-1:0] LP_BASE     = addr_width_g'(BASE_ADDR);
    localparam logic [addr_width_g-1:0] LP_LAST     = '1;
    localparam logic [addr_width_g-1:0] LP_A_ONE    = addr_width_g'(1);
    localparam logic [addr_width_g:0]   LP_B_ONE    = (addr_width_g+1)'(1);
    localparam logic [7:0]              LP_INDEX    = 8'(INDEX_MATCH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nx;

    logic                      r_act_q;
    logic                      r_skid_vld;
    logic [26:0]               r_skid_off;
    logic [data_width_g-1:0]   r_skid_data;
    logic [addr_width_g-1:0]   r_clr_addr;
    logic                      r_we;
    logic [addr_width_g-1:0]   r_ad;
    logic [data_width_g-1:0]   r_d;
    logic [addr_width_g:0]     r_bytes;
    logic                      r_ovf;

    logic                      w_act;
    logic                      w_wr;
    logic [26:0]               w_src_off;
    logic [data_width_g-1:0]   w_src_data;
    logic                      w_src_ok;
    logic                      w_start;
    logic                      w_wait;
    logic                      w_wr_en;
    logic [addr_width_g-1:0]   w_wr_ad;
    logic [data_width_g-1:0]   w_wr_d;
    logic                      w_count;
    logic                      w_ovf_set;
    logic                      w_skid_load;
    logic                      w_skid_clr;
    logic                      w_clr_step;

    assign w_act      = ioctl_download && (ioctl_index == LP_INDEX);
    assign w_wr       = ioctl_wr && w_act;

    // A buffered byte always goes out before any fresh strobe.
    assign w_src_off  = r_skid_vld ? r_skid_off  : ioctl_addr;
    assign w_src_data = r_skid_vld ? r_skid_data : ioctl_dout;
    assign w_src_ok   = ({1'b0, w_src_off} < LP_REGION);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_start     = 1'b0;
        w_wait      = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_ad     = '0;
        w_wr_d      = '0;
        w_count     = 1'b0;
        w_ovf_set   = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        w_clr_step  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_act && !r_act_q) begin
                    w_start     = 1'b1;
                    w_skid_load = w_wr;
                    w_state_nx  = CLEAR_EN ? S_CLEAR : S_LOAD;
                end
            end
            S_CLEAR: begin
                w_wait     = 1'b1;
                w_wr_en    = 1'b1;
                w_wr_ad    = r_clr_addr;
                w_wr_d     = FILL_VALUE;
                w_clr_step = 1'b1;
                if (w_wr) begin
                    if (r_skid_vld) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_skid_load = 1'b1;
                    end
                end
                if (r_clr_addr == LP_LAST) begin
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                w_wait = r_skid_vld;
                if (r_skid_vld || w_wr) begin
                    if (w_src_ok) begin
                        w_wr_en = 1'b1;
                        w_wr_ad = LP_BASE + w_src_off[addr_width_g-1:0];
                        w_wr_d  = w_src_data;
                        w_count = 1'b1;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                end
                if (r_skid_vld) begin
                    w_skid_clr = 1'b1;
                    if (w_wr) begin
                        w_ovf_set = 1'b1;
                    end
                end
                if (!r_act_q && !w_act && !r_skid_vld) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_act_q     <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_off  <= '0;
            r_skid_data <= '0;
            r_clr_addr  <= '0;
            r_we        <= 1'b0;
            r_ad        <= '0;
            r_d         <= '0;
            r_bytes     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_act_q <= w_act;
            r_we    <= w_wr_en;
            r_ad    <= w_wr_ad;
            r_d     <= w_wr_d;
            if (w_start) begin
                r_clr_addr <= LP_BASE;
            end else if (w_clr_step) begin
                r_clr_addr <= r_clr_addr + LP_A_ONE;
            end
            if (w_skid_load) begin
                r_skid_vld  <= 1'b1;
                r_skid_off  <= ioctl_addr;
                r_skid_data <= ioctl_dout;
            end else if (w_skid_clr) begin
                r_skid_vld  <= 1'b0;
            end
            if (w_start) begin
                r_bytes <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_count && (r_bytes != '1)) begin
                    r_bytes <= r_bytes + LP_B_ONE;
                end
                if (w_ovf_set) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign ioctl_wait    = w_wait;
    assign ram_cs_b      = r_we;
    assign ram_we_b      = r_we;
    assign ram_ad_b      = r_ad;
    assign ram_d_b       = r_d;
    assign cpu_hold      = (r_state == S_CLEAR) || (r_state == S_LOAD);
    assign load_done     = (r_state == S_DONE);
    assign load_bytes    = r_bytes;
    assign load_overflow = r_ovf;

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Sits directly upstream of the shared dual-port RAM and drives its port B.
- Takes the MiSTer HPS ioctl download stream (cartridge/ROM image) and writes it into the RAM at a fixed base address.
- Before loading, it optionally clears the target region to a fill value.
- Holds the CPU in reset for the whole load and reports the byte count and overflow.

Parameters:
- data_width_g, 8, RAM data width; must equal the ioctl byte width.
- addr_width_g, 14, RAM address width; matches the RAM instance.
- BASE_ADDR, 'h400, first RAM address of the cartridge region.
- INDEX_MATCH, 1, ioctl_index value this loader accepts; other indices are ignored.
- CLEAR_EN, 1, 1 = clear the region before loading.
- FILL_VALUE, 8'h00, byte written during clear.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  27  byte offset within the image.
- ioctl_dout  in  data_width_g  byte data.
- ioctl_wait  out  1  stall request to the HPS.
- ram_cs_b  out  1  port B select.
- ram_we_b  out  1  port B write enable.
- ram_ad_b  out  addr_width_g  port B address.
- ram_d_b  out  data_width_g  port B write data.
- cpu_hold  out  1  CPU reset request.
- load_done  out  1  one-cycle pulse at end of load.
- load_bytes  out  addr_width_g+1  bytes accepted in the last load; saturating.
- load_overflow  out  1  sticky; an offset fell beyond the region.

Behaviour:
- Active qualifier: act = ioctl_download && ioctl_index == INDEX_MATCH. The FSM samples a registered copy, act_q.
- Reset value of all outputs is 0. Reset has priority at any point, including mid-clear or mid-load: the FSM returns to IDLE, the skid buffer is emptied, and no write is issued in the cycle after reset.
- FSM states:
  - IDLE: on act rising (act && !act_q), clear load_bytes and load_overflow, set cpu_hold=1, then go to CLEAR if CLEAR_EN, else LOAD.
  - CLEAR: write FILL_VALUE at addresses BASE_ADDR .. 2**addr_width_g-1, one per cycle, ascending (ram_cs_b=ram_we_b=1). ioctl_wait=1 throughout. After the last address, go to LOAD. Default clear lasts 15360 cycles.
  - LOAD: ioctl_wait=0 unless the skid buffer is full. On ioctl_wr with offset = ioctl_addr:
    - If offset < 2**addr_width_g - BASE_ADDR: one cycle later ram_we_b=ram_cs_b=1, ram_ad_b = BASE_ADDR + offset[addr_width_g-1:0], ram_d_b = ioctl_dout. Write latency is exactly 1 cycle. load_bytes increments, saturating at all-ones.
    - Otherwise: no write; load_overflow is set.
    - On act falling, go to DONE once the skid buffer is empty.
  - DONE: load_done=1 for exactly one cycle, cpu_hold=0, then IDLE.
- Skid buffer (one entry): captures an ioctl_wr that arrives while the module cannot write it, i.e. in the rise cycle or during CLEAR. While the buffer is full, ioctl_wait=1. The captured byte is written in the first LOAD cycle, before any new strobe is processed. A second strobe arriving while the buffer is full is a protocol violation: it is dropped and load_overflow is set.
- Download ending during CLEAR: the clear completes, the buffered byte (if any) is written, then the FSM passes through LOAD to DONE.
- ioctl_wr while act=0 is ignored.
- ram_we_b is never asserted in IDLE or DONE. ram_cs_b is asserted only together with ram_we_b.
- Address sums are computed at addr_width_g bits; no wrap is possible because of the range check.

Test Plan:
- Reset, then download index 1 with 4 bytes AA,BB,CC,DD at offsets 0-3, CLEAR_EN=0 -> writes at 0x400-0x403 each 1 cycle after its strobe; load_bytes=4; load_done pulses once; cpu_hold high from the cycle after the rise until DONE.
- CLEAR_EN=1, download of 1 byte -> 15360 fill writes of 0x00 covering 0x400..0x3FFF with ioctl_wait=1; then byte written at 0x400; RAM 0x401 reads 0x00.
- Write strobe in the rise cycle (offset 0, data 5A) -> captured by the skid buffer, written at 0x400 after clear completes; load_bytes=1; no second strobe is lost.
- Offset 0x3C00 (beyond the 15360-byte region) -> no ram_we_b; load_overflow=1; load_bytes unchanged.
- Download with ioctl_index=0 -> no writes, cpu_hold stays 0, no load_done.
- reset asserted mid-clear at address 0x800 -> next cycle all outputs 0, state IDLE; a new download restarts the clear at 0x400.
